// File: rtl/sea_pkg.sv
// Shared definitions for the SEA round controller: state encoding, widths and modes.
package sea_pkg;

   localparam int SEA_HW = 48;
   localparam int SEA_KW = 96;

   localparam logic SEA_ENC = 1'b0;
   localparam logic SEA_DEC = 1'b1;

   typedef enum logic [1:0] {
      SEA_IDLE = 2'd0,
      SEA_RUN  = 2'd1,
      SEA_DONE = 2'd2
   } sea_state_e;

endpackage

// File: rtl/sea_round_cnt.sv
// Round counter for the SEA controller; tc flags the last round (NR-1) and the
// count parks there instead of wrapping.
import sea_pkg::*;

module sea_round_cnt #(
   parameter int NR = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] cnt,
   output logic       tc
);

   assign tc = (cnt == 8'(NR - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !tc) begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/sea_round_ctrl.sv
// Iterative SEA block controller driving an external single-round datapath.
// Optional feature: define SEA_ROUND_CTRL_CNT_EN to add the blk_cnt handshake counter.
//
//  state | meaning
//  IDLE  | waiting for a block, in_ready=1
//  RUN   | one round per cycle, NR cycles
//  DONE  | result held; out_valid rises one cycle after entry (output register stage)
import sea_pkg::*;

module sea_round_ctrl #(
   parameter int NR = 16,
   parameter int HW = SEA_HW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_mode,
   input  logic [HW-1:0]   in_l,
   input  logic [HW-1:0]   in_r,
   input  logic [2*HW-1:0] in_key,
   output logic [HW-1:0]   rnd_l,
   output logic [HW-1:0]   rnd_r,
   output logic [2*HW-1:0] rnd_k,
   output logic            rnd_mode,
   output logic [7:0]      rnd_idx,
   input  logic [HW-1:0]   rnd_nl,
   input  logic [HW-1:0]   rnd_nr,
   input  logic [2*HW-1:0] rnd_nk,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [HW-1:0]   out_l,
   output logic [HW-1:0]   out_r
`ifdef SEA_ROUND_CTRL_CNT_EN
   ,
   output logic [15:0]     blk_cnt
`endif
);

   localparam logic [1:0] S_IDLE = SEA_IDLE;
   localparam logic [1:0] S_RUN  = SEA_RUN;
   localparam logic [1:0] S_DONE = SEA_DONE;

   logic [1:0]      state_q;
   logic [HW-1:0]   l_q;
   logic [HW-1:0]   r_q;
   logic [2*HW-1:0] k_q;
   logic            mode_q;
   logic            ov_q;
   logic [7:0]      cnt;
   logic            tc;
   logic            accept;
   logic            take;

   assign in_ready = (state_q == S_IDLE);
   assign accept   = in_ready & in_valid;
   assign take     = ov_q & out_ready;

   sea_round_cnt #(.NR(NR)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .inc (state_q == S_RUN),
      .cnt (cnt),
      .tc  (tc)
   );

   assign rnd_l     = l_q;
   assign rnd_r     = r_q;
   assign rnd_k     = k_q;
   assign rnd_mode  = mode_q;
   assign rnd_idx   = cnt;
   assign out_valid = ov_q;
   assign out_l     = l_q;
   assign out_r     = r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         l_q     <= '0;
         r_q     <= '0;
         k_q     <= '0;
         mode_q  <= SEA_ENC;
         ov_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  l_q     <= in_l;
                  r_q     <= in_r;
                  k_q     <= in_key;
                  mode_q  <= in_mode;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               l_q <= rnd_nl;
               r_q <= rnd_nr;
               k_q <= rnd_nk;
               if (tc) state_q <= S_DONE;
            end
            S_DONE: begin
               if (take) begin
                  ov_q    <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  ov_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef SEA_ROUND_CTRL_CNT_EN
   logic [15:0] blk_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt_q <= '0;
      end else if (take) begin
         blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sea_round_ctrl.sv
// Directed bench for sea_round_ctrl with NR=4 and a stub round datapath.
module tb_sea_round_ctrl;

   localparam int HW = 48;
   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic            in_mode;
   logic [HW-1:0]   in_l;
   logic [HW-1:0]   in_r;
   logic [2*HW-1:0] in_key;
   logic [HW-1:0]   rnd_l;
   logic [HW-1:0]   rnd_r;
   logic [2*HW-1:0] rnd_k;
   logic            rnd_mode;
   logic [7:0]      rnd_idx;
   logic [HW-1:0]   rnd_nl;
   logic [HW-1:0]   rnd_nr;
   logic [2*HW-1:0] rnd_nk;
   logic            out_valid;
   logic            out_ready;
   logic [HW-1:0]   out_l;
   logic [HW-1:0]   out_r;
`ifdef SEA_ROUND_CTRL_CNT_EN
   logic [15:0]     blk_cnt;
`endif

   int errors = 0;
   int checks = 0;

   logic [HW-1:0] exp_l [4] = '{48'h1, 48'h2, 48'hE, 48'hD};

   always #5 clk = ~clk;

   assign rnd_nl = rnd_r;
   assign rnd_nr = rnd_l ^ rnd_k[HW-1:0];
   assign rnd_nk = rnd_k;

   sea_round_ctrl #(.NR(NR), .HW(HW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_l      (in_l),
      .in_r      (in_r),
      .in_key    (in_key),
      .rnd_l     (rnd_l),
      .rnd_r     (rnd_r),
      .rnd_k     (rnd_k),
      .rnd_mode  (rnd_mode),
      .rnd_idx   (rnd_idx),
      .rnd_nl    (rnd_nl),
      .rnd_nr    (rnd_nr),
      .rnd_nk    (rnd_nk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_l     (out_l),
      .out_r     (out_r)
`ifdef SEA_ROUND_CTRL_CNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic mode, input logic [HW-1:0] l, input logic [HW-1:0] r,
                          input logic [2*HW-1:0] k);
      in_valid = 1'b1;
      in_mode  = mode;
      in_l     = l;
      in_r     = r;
      in_key   = k;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_mode = 1'b0; in_l = '0; in_r = '0; in_key = '0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (rnd_idx !== 8'd0) begin errors++; $display("FAIL reset_rnd_idx: got %0d expected 0", rnd_idx); end
      checks++; if (rnd_l !== '0 || rnd_k !== '0) begin errors++; $display("FAIL reset_regs: got l=%h k=%h expected 0", rnd_l, rnd_k); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      present(1'b0, 48'h1, 48'h2, 96'hF);
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_run: got %b expected 0", in_ready); end
      for (int i = 0; i < NR; i++) begin
         checks++; if (rnd_l !== exp_l[i]) begin errors++; $display("FAIL basic_rnd_l[%0d]: got %h expected %h", i, rnd_l, exp_l[i]); end
         checks++; if (rnd_idx !== 8'(i)) begin errors++; $display("FAIL basic_rnd_idx[%0d]: got %0d expected %0d", i, rnd_idx, i); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_early[%0d]: got %b expected 0", i, out_valid); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_t4: got %b expected 0", out_valid); end
      checks++; if (rnd_idx !== 8'(NR - 1)) begin errors++; $display("FAIL basic_idx_park: got %0d expected %0d", rnd_idx, NR - 1); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid_t5: got %b expected 1", out_valid); end
      checks++; if (out_l !== 48'h1 || out_r !== 48'h2) begin errors++; $display("FAIL basic_result: got l=%h r=%h expected 1 2", out_l, out_r); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_after_take: got ov=%b rdy=%b expected 0 1", out_valid, in_ready); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      present(1'b1, 48'h1, 48'h2, 96'hF);
      tick();
      checks++; if (rnd_mode !== 1'b1) begin errors++; $display("FAIL bp_rnd_mode: got %b expected 1", rnd_mode); end
      present(1'b0, 48'hAAAA, 48'h5555, 96'h3);
      for (int i = 0; i < NR + 1; i++) tick();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_l !== 48'h1 || out_r !== 48'h2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got ov=%b l=%h r=%h rdy=%b expected 1 1 2 0", i, out_valid, out_l, out_r, in_ready);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ov=%b rdy=%b expected 0 1", out_valid, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_single_take: got ov=%b rdy=%b expected 0 1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      present(1'b0, 48'h5, 48'h9, 96'h3);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checks++; if (rnd_idx !== 8'd2) begin errors++; $display("FAIL rstmid_idx: got %0d expected 2", rnd_idx); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1 || rnd_idx !== 8'd0 || rnd_l !== '0) begin
         errors++; $display("FAIL rstmid_idle: got rdy=%b idx=%0d l=%h expected 1 0 0", in_ready, rnd_idx, rnd_l);
      end
      for (int i = 0; i < 8; i++) begin
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid[%0d]: got %b expected 0", i, out_valid); end
         tick();
      end
      present(1'b0, 48'h1, 48'h2, 96'hF);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NR + 1; i++) tick();
      checks++; if (out_valid !== 1'b1 || out_l !== 48'h1 || out_r !== 48'h2) begin
         errors++; $display("FAIL rstmid_next_block: got ov=%b l=%h r=%h expected 1 1 2", out_valid, out_l, out_r);
      end
      tick();
   endtask

   task automatic test_input_ignore();
      out_ready = 1'b0;
      present(1'b0, 48'h1, 48'h2, 96'hF);
      tick();
      for (int i = 0; i < NR; i++) begin
         in_l = 48'h100 + 48'(i);
         in_r = 48'h200 + 48'(i);
         checks++; if (rnd_l !== exp_l[i]) begin errors++; $display("FAIL ign_rnd_l[%0d]: got %h expected %h", i, rnd_l, exp_l[i]); end
         tick();
      end
      in_l = 48'h777;
      tick();
      checks++; if (out_valid !== 1'b1 || out_l !== 48'h1 || out_r !== 48'h2) begin
         errors++; $display("FAIL ign_result: got ov=%b l=%h r=%h expected 1 1 2", out_valid, out_l, out_r);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ign_take: got rdy=%b ov=%b expected 1 0", in_ready, out_valid); end
   endtask

`ifdef SEA_ROUND_CTRL_CNT_EN
   task automatic test_blk_cnt();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d expected 0", blk_cnt); end
      for (int b = 0; b < 3; b++) begin
         present(1'b0, 48'h1, 48'h2, 96'hF);
         tick();
         in_valid = 1'b0;
         for (int i = 0; i < NR + 2; i++) tick();
         checks++; if (blk_cnt !== 16'(b + 1)) begin errors++; $display("FAIL cnt_b2b[%0d]: got %0d expected %0d", b, blk_cnt, b + 1); end
      end
      force dut.blk_cnt_q = 16'hFFFF;
      tick();
      release dut.blk_cnt_q;
      present(1'b0, 48'h1, 48'h2, 96'hF);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NR + 2; i++) tick();
      checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL cnt_wrap: got %h expected 0", blk_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid();
      test_input_ignore();
`ifdef SEA_ROUND_CTRL_CNT_EN
      test_blk_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sea_round_ctrl.md
SEA_ROUND_CTRL -- requirements
Module: sea_round_ctrl

Interface
REQ-001 Parameter NR, default 16, number of SEA rounds per block; legal range 2..255.
REQ-002 Parameter HW, default 48, width of one half-block; key width is 2*HW.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  request carries a block; in_ready  out  1  controller accepts.
REQ-006 in_mode  in  1  0 = encrypt, 1 = decrypt; in_l, in_r  in  HW  plaintext/ciphertext halves; in_key  in  2*HW  block key.
REQ-007 rnd_l, rnd_r  out  HW  and rnd_k  out  2*HW  are operands driven to the shared single-round datapath.
REQ-008 rnd_mode  out  1  and rnd_idx  out  8  are the mode and round index (0..NR-1) for the datapath.
REQ-009 rnd_nl, rnd_nr  in  HW  and rnd_nk  in  2*HW  are the datapath's combinational round results.
REQ-010 out_valid  out  1  result held; out_ready  in  1  consumer takes it; out_l, out_r  out  HW  result halves.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-013 On acceptance: latch in_l/in_r/in_key/in_mode into L/R/K/mode regs, clear the round counter, go to RUN.
REQ-014 In RUN: rnd_l=L, rnd_r=R, rnd_k=K, rnd_mode=mode, rnd_idx=counter; each edge loads L<=rnd_nl, R<=rnd_nr, K<=rnd_nk, counter+1.
REQ-015 The edge with counter=NR-1 SHALL perform the final round and move to DONE; exactly NR round cycles per block.
REQ-016 Latency: accept at edge T -> out_valid first high after edge T+NR+1.
REQ-017 In DONE: out_valid=1, out_l=L, out_r=R, held stable until out_valid & out_ready, then IDLE.
REQ-018 No new block is accepted in the same cycle a result is taken; the next acceptance happens at the earliest edge after return to IDLE.
REQ-019 Inputs in_* are ignored outside IDLE; changes on in_* during RUN/DONE have no effect.
REQ-020 out_valid SHALL be 0 in IDLE and RUN; out_l/out_r hold the last register values (don't-care to the consumer).
REQ-021 rnd_idx SHALL never exceed NR-1; the counter does not wrap within a block.

Reset
REQ-022 While rst=1 at an edge: state<=IDLE, counter<=0, L/R/K<=0, mode<=0; out_valid=0, in_ready=1 after the edge.
REQ-023 Reset mid-RUN or mid-DONE SHALL discard the in-flight block with no output handshake; reset has priority over every other event.

Configuration
REQ-024 Macro SEA_ROUND_CTRL_CNT_EN defined: extra output blk_cnt  out  16  counts completed output handshakes, reset 0, wraps 0xFFFF->0.
REQ-025 Macro SEA_ROUND_CTRL_CNT_EN undefined: no blk_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-026 Package sea_pkg SHALL hold the FSM state enum, SEA_HW=48, SEA_KW=96 and the mode encodings (SEA_ENC=0, SEA_DEC=1).
REQ-027 One sub-module, sea_round_cnt (round counter with terminal-count flag at NR-1), SHALL be instantiated; the round datapath remains external.

Verification
REQ-028 The bench uses a stub datapath: rnd_nl=rnd_r, rnd_nr=rnd_l^rnd_k[HW-1:0], rnd_nk=rnd_k.
REQ-029 NR=4, enc, l=0x1, r=0x2, key low=0xF -> rnd_l sequence 1,2,E,D; out_l=0x1, out_r=0x2; out_valid first high after edge T+5.
REQ-030 Same block, out_ready held 0 for 10 cycles -> out_valid and out_l/out_r stable throughout; in_ready=0; single handshake on release.
REQ-031 rst pulsed at round 2 of a block -> IDLE next cycle, out_valid never asserts, following block from REQ-029 completes correctly.
REQ-032 in_valid held 1 with in_l changing every cycle during RUN -> result equals the block latched at acceptance.
REQ-033 SEA_ROUND_CTRL_CNT_EN defined, 3 back-to-back blocks with out_ready=1 -> blk_cnt = 1, 2, 3 after each handshake; preloaded to 0xFFFF -> wraps to 0.
